// File: rtl/station_pkg.sv
// Shared types and defaults for the station scheduler.
// Optional feature macro used by the scheduler: STATION_TIMEOUT_EN.
package station_pkg;

   localparam int unsigned N_REQ_DEF  = 4;
   localparam int unsigned CODE_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_ABORT = 2'd3
   } state_e;

endpackage : station_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter
   import station_pkg::*;
#(
   parameter  int unsigned N_REQ = N_REQ_DEF,
   localparam int unsigned PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] win_c,
   output logic             valid_c
);

   logic [PTR_W-1:0] idx;

   // Scan requesters in rotating order from the pointer; keep the first hit
   always_comb begin
      win_c   = '0;
      valid_c = 1'b0;
      idx     = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = PTR_W'((32'(ptr) + k) % N_REQ);
         if (!valid_c && req[idx]) begin
            win_c[idx] = 1'b1;
            valid_c    = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/station_scheduler.sv
// Round-robin sharing of one station unit between N_REQ requesters.
// Define STATION_TIMEOUT_EN to abort RUN after TIMEOUT cycles without unit_done.
module station_scheduler
   import station_pkg::*;
#(
   parameter int unsigned N_REQ   = N_REQ_DEF,
   parameter int unsigned CODE_W  = CODE_W_DEF
`ifdef STATION_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = 64
`endif
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*CODE_W-1:0]   req_code,
   output logic [N_REQ-1:0]          grant,
   output logic [N_REQ-1:0]          done_pulse,
   output logic                      unit_enable,
   output logic [CODE_W-1:0]         unit_code,
   input  logic                      unit_done,
   output logic                      busy,
   output logic                      err
);

   localparam int unsigned PTR_W = $clog2(N_REQ);
`ifdef STATION_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT);
`endif

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [N_REQ-1:0]   done_pulse_q, done_pulse_d;
   logic               unit_enable_q, unit_enable_d;
   logic [CODE_W-1:0]  unit_code_q, unit_code_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
`ifdef STATION_TIMEOUT_EN
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

   logic [N_REQ-1:0]   win_c;
   logic               win_valid_c;
   logic [PTR_W-1:0]   win_idx_c;
   logic [CODE_W-1:0]  win_code_c;
   logic [PTR_W-1:0]   ptr_next_c;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .win_c   (win_c),
      .valid_c (win_valid_c)
   );

   // Encode the one-hot winner into an index and select its code
   always_comb begin
      win_idx_c  = '0;
      win_code_c = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win_c[i]) begin
            win_idx_c  = PTR_W'(i);
            win_code_c = req_code[i*CODE_W +: CODE_W];
         end
      end
   end

   // Pointer moves to the requester after the finishing owner
   always_comb begin
      ptr_next_c = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
   end

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      done_pulse_d  = '0;
      unit_enable_d = unit_enable_q;
      unit_code_d   = unit_code_q;
      busy_d        = busy_q;
      err_d         = 1'b0;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
`ifdef STATION_TIMEOUT_EN
      cnt_d         = cnt_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (win_valid_c) begin
               state_d       = ST_RUN;
               grant_d       = win_c;
               unit_code_d   = win_code_c;
               unit_enable_d = 1'b1;
               busy_d        = 1'b1;
               owner_d       = win_idx_c;
`ifdef STATION_TIMEOUT_EN
               cnt_d         = '0;
`endif
            end
         end
         ST_RUN: begin
            if (unit_done) begin
               state_d       = ST_DONE;
               grant_d       = '0;
               unit_enable_d = 1'b0;
               done_pulse_d  = grant_q;
               ptr_d         = ptr_next_c;
            end
`ifdef STATION_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d       = ST_ABORT;
               grant_d       = '0;
               unit_enable_d = 1'b0;
               done_pulse_d  = grant_q;
               err_d         = 1'b1;
               ptr_d         = ptr_next_c;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         ST_DONE, ST_ABORT: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         grant_q       <= '0;
         done_pulse_q  <= '0;
         unit_enable_q <= 1'b0;
         unit_code_q   <= '0;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
         ptr_q         <= '0;
         owner_q       <= '0;
`ifdef STATION_TIMEOUT_EN
         cnt_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         done_pulse_q  <= done_pulse_d;
         unit_enable_q <= unit_enable_d;
         unit_code_q   <= unit_code_d;
         busy_q        <= busy_d;
         err_q         <= err_d;
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
`ifdef STATION_TIMEOUT_EN
         cnt_q         <= cnt_d;
`endif
      end
   end

   assign grant       = grant_q;
   assign done_pulse  = done_pulse_q;
   assign unit_enable = unit_enable_q;
   assign unit_code   = unit_code_q;
   assign busy        = busy_q;
   assign err         = err_q;

endmodule : station_scheduler
